// File: rtl/rv_pipe_pkg.sv
// Shared RV pipeline definitions: opcodes, the NOP word, the control bundle and
// the operand-usage helpers used for hazard detection.
package rv_pipe_pkg;

    localparam logic [6:0] MATHr  = 7'b0110011;
    localparam logic [6:0] MATHWr = 7'b0111011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] LW     = 7'b0000011;

    localparam logic [31:0] RV_NOP_INST = 32'h00000013;

    typedef struct packed {
        logic we_reg;
        logic re_mem;
        logic we_mem;
    } ctrl_t;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !((opcode == JAL) || (opcode == LUI) || (opcode == AUIPC));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == MATHr) || (opcode == MATHWr) || (opcode == BRANCH) || (opcode == SW);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector: flags an ID instruction that reads
// the destination of a load currently in EX.
module hazard_detect
    import rv_pipe_pkg::*;
#(
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic [31:0] id_inst,
    input  logic        id_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_valid,
    input  logic        ex_re_mem,
    output logic        hz
);

    logic [6:0] opcode_s;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
    logic       reads_rd_s;

    assign opcode_s = id_inst[6:0];
    assign rs1_s    = id_inst[19:15];
    assign rs2_s    = id_inst[24:20];

    // Hazard only when a valid load to a non-zero rd feeds a real source operand
    always_comb begin
        reads_rd_s = 1'b0;
        hz         = 1'b0;
        if ((uses_rs1(opcode_s) && (rs1_s == ex_rd)) || (uses_rs2(opcode_s) && (rs2_s == ex_rd))) begin
            reads_rd_s = 1'b1;
        end else begin
            reads_rd_s = 1'b0;
        end
        if (LOAD_USE_STALL && id_valid && ex_valid && ex_re_mem && (ex_rd != 5'd0) && reads_rd_s) begin
            hz = 1'b1;
        end else begin
            hz = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush handling.
// Optional bubble counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
    import rv_pipe_pkg::*;
#(
    parameter bit          LOAD_USE_STALL = 1'b1,
    parameter logic [31:0] NOP_INST       = RV_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_inst,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic        id_we_reg,
    input  logic        id_re_mem,
    input  logic        id_we_mem,
    input  logic        ex_flush,
    input  logic        mem_stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_inst,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic        ex_we_reg,
    output logic        ex_re_mem,
    output logic        ex_we_mem,
    output logic        id_stall
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0] perf_luse_bubbles,
    output logic [31:0] perf_flush_bubbles
`endif
);

    logic        valid_r;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic [31:0] rs1_data_r;
    logic [31:0] rs2_data_r;
    logic [31:0] imm_r;
    ctrl_t       ctrl_r;
    ctrl_t       id_ctrl_s;
    logic        hz_s;

    hazard_detect #(
        .LOAD_USE_STALL (LOAD_USE_STALL)
    ) u_hazard_detect (
        .id_inst   (id_inst),
        .id_valid  (id_valid),
        .ex_rd     (inst_r[11:7]),
        .ex_valid  (valid_r),
        .ex_re_mem (ctrl_r.re_mem),
        .hz        (hz_s)
    );

    // Control bits of an invalid ID slot are forced off so they never reach EX
    always_comb begin
        id_ctrl_s = '0;
        if (id_valid) begin
            id_ctrl_s.we_reg = id_we_reg;
            id_ctrl_s.re_mem = id_re_mem;
            id_ctrl_s.we_mem = id_we_mem;
        end else begin
            id_ctrl_s = '0;
        end
    end

    // Pipeline register: reset, freeze, flush bubble, load-use bubble, advance
    always_ff @(posedge clk) begin
        if (rst || (!mem_stall && (ex_flush || hz_s))) begin
            valid_r    <= 1'b0;
            pc_r       <= 32'd0;
            inst_r     <= NOP_INST;
            rs1_data_r <= 32'd0;
            rs2_data_r <= 32'd0;
            imm_r      <= 32'd0;
            ctrl_r     <= '0;
        end else if (mem_stall) begin
            valid_r    <= valid_r;
            pc_r       <= pc_r;
            inst_r     <= inst_r;
            rs1_data_r <= rs1_data_r;
            rs2_data_r <= rs2_data_r;
            imm_r      <= imm_r;
            ctrl_r     <= ctrl_r;
        end else begin
            valid_r    <= id_valid;
            pc_r       <= id_pc;
            inst_r     <= id_inst;
            rs1_data_r <= id_rs1_data;
            rs2_data_r <= id_rs2_data;
            imm_r      <= id_imm;
            ctrl_r     <= id_ctrl_s;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] luse_cnt_r;
    logic [31:0] flush_cnt_r;

    // A flush takes precedence, so a coincident hazard is not counted as load-use
    always_ff @(posedge clk) begin
        if (rst) begin
            luse_cnt_r  <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else if (mem_stall) begin
            luse_cnt_r  <= luse_cnt_r;
            flush_cnt_r <= flush_cnt_r;
        end else if (ex_flush) begin
            flush_cnt_r <= flush_cnt_r + 32'd1;
        end else if (hz_s) begin
            luse_cnt_r  <= luse_cnt_r + 32'd1;
        end else begin
            luse_cnt_r  <= luse_cnt_r;
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign perf_luse_bubbles  = luse_cnt_r;
    assign perf_flush_bubbles = flush_cnt_r;
`endif

    assign id_stall    = mem_stall | (hz_s & ~ex_flush);
    assign ex_valid    = valid_r;
    assign ex_pc       = pc_r;
    assign ex_inst     = inst_r;
    assign ex_rs1_data = rs1_data_r;
    assign ex_rs2_data = rs2_data_r;
    assign ex_imm      = imm_r;
    assign ex_we_reg   = ctrl_r.we_reg;
    assign ex_re_mem   = ctrl_r.re_mem;
    assign ex_we_mem   = ctrl_r.we_mem;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios followed by
// randomized traffic, all compared against a behavioural EX-slot model.
`timescale 1ns/1ps
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = 32'd0;
    logic [31:0] id_inst = 32'h00000013;
    logic [31:0] id_rs1_data = 32'd0;
    logic [31:0] id_rs2_data = 32'd0;
    logic [31:0] id_imm = 32'd0;
    logic        id_we_reg = 1'b0;
    logic        id_re_mem = 1'b0;
    logic        id_we_mem = 1'b0;
    logic        ex_flush = 1'b0;
    logic        mem_stall = 1'b0;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_inst, ex_rs1_data, ex_rs2_data, ex_imm;
    logic        ex_we_reg, ex_re_mem, ex_we_mem, id_stall;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_luse_bubbles, perf_flush_bubbles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage #(.LOAD_USE_STALL(1'b1), .NOP_INST(32'h00000013)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_we_reg(id_we_reg), .id_re_mem(id_re_mem), .id_we_mem(id_we_mem),
        .ex_flush(ex_flush), .mem_stall(mem_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_inst(ex_inst), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_we_reg(ex_we_reg), .ex_re_mem(ex_re_mem),
        .ex_we_mem(ex_we_mem), .id_stall(id_stall)
`ifdef ID_EX_PERF_CNT_EN
        , .perf_luse_bubbles(perf_luse_bubbles), .perf_flush_bubbles(perf_flush_bubbles)
`endif
    );

    always #5 clk = ~clk;

    // Reference model of what EX should hold
    typedef struct {
        bit          valid;
        logic [31:0] pc, inst, rs1, rs2, imm;
        bit          we_reg, re_mem, we_mem;
    } slot_t;
    slot_t       m;
    logic [31:0] m_luse = 32'd0;
    logic [31:0] m_flush = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Does instruction word w read architectural register r as a source?
    function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
        logic [6:0] op;
        bit s1, s2;
        op = w[6:0];
        s1 = !(op == 7'b1101111 || op == 7'b0110111 || op == 7'b0010111);
        s2 = (op == 7'b0110011 || op == 7'b0111011 || op == 7'b1100011 || op == 7'b0100011);
        return (s1 && w[19:15] == r) || (s2 && w[24:20] == r);
    endfunction

    function automatic slot_t bubble();
        slot_t b;
        b.valid = 0; b.pc = 0; b.inst = 32'h00000013; b.rs1 = 0; b.rs2 = 0; b.imm = 0;
        b.we_reg = 0; b.re_mem = 0; b.we_mem = 0;
        return b;
    endfunction

    task automatic set_id(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                          input bit wr, input bit rm, input bit wm);
        id_valid = v; id_pc = pc; id_inst = inst;
        id_we_reg = wr; id_re_mem = rm; id_we_mem = wm;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    endtask

    // One clock: check id_stall before the edge, advance model, check EX after it
    task automatic step(input bit fl, input bit ms, input bit rs);
        bit hz;
        ex_flush = fl; mem_stall = ms; rst = rs;
        #1;
        hz = id_valid && m.valid && m.re_mem && (m.inst[11:7] != 5'd0) && reads_reg(id_inst, m.inst[11:7]);
        check("id_stall", {31'd0, id_stall}, {31'd0, (ms || (hz && !fl))});
        @(posedge clk);
        if (rs) begin
            m = bubble(); m_luse = 0; m_flush = 0;
        end else if (ms) begin
            m = m;
        end else if (fl) begin
            m = bubble(); m_flush++;
        end else if (hz) begin
            m = bubble(); m_luse++;
        end else begin
            m.valid = id_valid; m.pc = id_pc; m.inst = id_inst;
            m.rs1 = id_rs1_data; m.rs2 = id_rs2_data; m.imm = id_imm;
            m.we_reg = id_valid && id_we_reg; m.re_mem = id_valid && id_re_mem;
            m.we_mem = id_valid && id_we_mem;
        end
        #1;
        check("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
        check("ex_pc", ex_pc, m.pc);
        check("ex_inst", ex_inst, m.inst);
        check("ex_rs1_data", ex_rs1_data, m.rs1);
        check("ex_rs2_data", ex_rs2_data, m.rs2);
        check("ex_imm", ex_imm, m.imm);
        check("ex_ctrl", {29'd0, ex_we_reg, ex_re_mem, ex_we_mem}, {29'd0, m.we_reg, m.re_mem, m.we_mem});
`ifdef ID_EX_PERF_CNT_EN
        check("perf_luse", perf_luse_bubbles, m_luse);
        check("perf_flush", perf_flush_bubbles, m_flush);
`endif
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom;
        case ($urandom_range(0, 8))
            0: op = 7'b0110011;
            1: op = 7'b0111011;
            2: op = 7'b1101111;
            3: op = 7'b1100011;
            4: op = 7'b0110111;
            5: op = 7'b0010111;
            6: op = 7'b0100011;
            7: op = 7'b0000011;
            default: op = 7'b0010011;
        endcase
        w[6:0]   = op;
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    localparam logic [31:0] LW_X5   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] ADD_X6  = {7'd0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] LW_X7   = {12'd0, 5'd1, 3'b010, 5'd7, 7'b0000011};
    localparam logic [31:0] ADDI_X8 = {12'd7, 5'd1, 3'b000, 5'd8, 7'b0010011};
    localparam logic [31:0] LW_X0   = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
    localparam logic [31:0] ADD_X1  = {7'd0, 5'd0, 5'd0, 3'b000, 5'd1, 7'b0110011};

    initial begin
        logic [31:0] w;
        m = bubble();
        @(negedge clk);
        set_id(1, 32'h40, LW_X5, 1, 1, 0); step(0, 0, 1);
        // Load-use on rs1: one bubble, then the add advances
        step(0, 0, 0);
        set_id(1, 32'h44, ADD_X6, 1, 0, 0); step(0, 0, 0);
        check("luse_bubble_inst", ex_inst, 32'h00000013);
        step(0, 0, 0);
        check("luse_add_reaches_ex", ex_inst, ADD_X6);
        // rs2 field match ignored for addi
        set_id(1, 32'h48, LW_X7, 1, 1, 0); step(0, 0, 0);
        set_id(1, 32'h4c, ADDI_X8, 1, 0, 0); step(0, 0, 0);
        check("addi_no_bubble", ex_inst, ADDI_X8);
        // Flush beats stall
        set_id(1, 32'h50, LW_X5, 1, 1, 0); step(0, 0, 0);
        set_id(1, 32'h54, ADD_X6, 1, 0, 0); step(1, 0, 0);
        // mem_stall hold for three cycles with changing ID
        set_id(1, 32'h100, ADD_X1, 1, 0, 0); step(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h200 + 32'(i), rand_inst(), 1, 0, 0); step(0, 1, 0);
            check("mem_stall_hold_pc", ex_pc, 32'h100);
        end
        // x0 destination never stalls
        set_id(1, 32'h60, LW_X0, 1, 1, 0); step(0, 0, 0);
        set_id(1, 32'h64, ADD_X1, 1, 0, 0); step(0, 0, 0);
        // Reset during a hazard cycle
        set_id(1, 32'h70, LW_X5, 1, 1, 0); step(0, 0, 0);
        set_id(1, 32'h74, ADD_X6, 1, 0, 0); step(0, 0, 1);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            w = rand_inst();
            set_id($urandom_range(0, 7) != 0, $urandom, w,
                   !(w[6:0] == 7'b0100011 || w[6:0] == 7'b1100011),
                   w[6:0] == 7'b0000011, w[6:0] == 7'b0100011);
            step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV core, with load-use hazard detection and bubble/flush control.
- Captures the decoded instruction, operands, immediate and control bits from ID, and presents them to EX one cycle later.
- Its ex_inst, ex_re_mem and ex_we_reg outputs feed the EX-stage forwarding unit and the EX/MEM register.
- Generates id_stall, which holds the PC and IF/ID registers.

Parameters:
- LOAD_USE_STALL, 1: 1 inserts a bubble on a load-use hazard; 0 disables detection and relies on MEM-stage load-data forwarding.
- NOP_INST, 32'h00000013: instruction word presented during a bubble (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_pc  input  32  PC of the ID instruction.
- id_inst  input  32  raw ID instruction.
- id_rs1_data  input  32  register-file read port 1.
- id_rs2_data  input  32  register-file read port 2.
- id_imm  input  32  sign-extended immediate.
- id_we_reg  input  1  instruction writes rd.
- id_re_mem  input  1  instruction is a load.
- id_we_mem  input  1  instruction is a store.
- ex_flush  input  1  EX redirect: branch taken, or JAL/JALR.
- mem_stall  input  1  data memory not ready; freeze the pipe.
- ex_valid  output  1  EX holds a real instruction.
- ex_pc  output  32  registered id_pc.
- ex_inst  output  32  registered id_inst, or NOP_INST.
- ex_rs1_data  output  32  registered id_rs1_data.
- ex_rs2_data  output  32  registered id_rs2_data.
- ex_imm  output  32  registered id_imm.
- ex_we_reg  output  1  registered id_we_reg.
- ex_re_mem  output  1  registered id_re_mem.
- ex_we_mem  output  1  registered id_we_mem.
- id_stall  output  1  combinational; hold PC and IF/ID this cycle.

Behaviour:
- Reset (synchronous):
  - ex_valid=0, ex_inst=NOP_INST.
  - ex_pc, ex_rs1_data, ex_rs2_data, ex_imm = 0.
  - ex_we_reg, ex_re_mem, ex_we_mem = 0.
  - rst asserted mid-operation discards any in-flight instruction and bubble on the next edge.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Field extraction: rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7], opcode=inst[6:0].
- Operand use:
  - uses_rs1 is false for JAL, LUI and AUIPC; true otherwise.
  - uses_rs2 is true for R-type (0110011), R-W (0111011), BRANCH and SW only.
- Hazard condition, hz, is true when all of the following hold:
  - LOAD_USE_STALL=1, id_valid, ex_valid, ex_re_mem, and ex rd!=0.
  - The ID instruction reads the EX rd: (uses_rs1 and rs1==ex rd) or (uses_rs2 and rs2==ex rd).
- Per-edge update, priority high to low:
  1. rst: apply reset values.
  2. mem_stall: hold every ex_* register unchanged.
  3. ex_flush: load a bubble (ex_valid=0, ex_inst=NOP_INST, all control bits 0, data fields 0).
  4. hz: load a bubble.
  5. Otherwise: load the ID fields; ex_valid=id_valid; control bits are gated to 0 when id_valid=0.
- id_stall = mem_stall OR (hz AND NOT ex_flush).
  - A flush overrides a load-use stall, because the ID instruction is wrong-path.
- A load-use hazard produces exactly one bubble: after the bubble, ex_valid=0, so hz drops and ID advances the next cycle.
- Back-to-back loads to the same rd: each dependent consumer stalls independently; no accumulated state.
- A bubble never asserts ex_we_reg or ex_we_mem, so downstream forwarding never matches it.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_luse_bubbles[31:0] and perf_flush_bubbles[31:0].
  - Each increments by 1 on every edge where its bubble is loaded (priority rules above apply; a mem_stall cycle counts nothing).
  - Counters wrap modulo 2^32 and reset to 0 on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rv_pipe_pkg:
  - Opcode constants: MATHr, MATHWr, JAL, BRANCH, LUI, AUIPC, SW, LW.
  - NOP_INST value.
  - ctrl_t bundle {we_reg, re_mem, we_mem}.
- Sub-module hazard_detect: combinational; takes the ID instruction, id_valid, ex rd, ex_valid and ex_re_mem; outputs hz.
- The register and priority logic stays in id_ex_stage.

Test Plan:
- Load-use on rs1:
  - Stimulus: EX=lw x5,0(x1) valid; ID=add x6,x5,x2.
  - Required: id_stall=1; next cycle ex_valid=0 with ex_inst=0x00000013; following cycle the add reaches EX.
- Load-use on rs2 only for uses_rs2:
  - Stimulus: EX=lw x7; ID=addi x8,x1,7 (inst[24:20] happens to equal 7).
  - Required: no stall, because addi does not use rs2; the addi reaches EX next cycle.
- Flush beats stall:
  - Stimulus: ex_flush=1 and hz=1 in the same cycle.
  - Required: id_stall=0; bubble loaded; perf_flush_bubbles increments, perf_luse_bubbles unchanged.
- mem_stall hold:
  - Stimulus: ex_pc=0x100 registered; mem_stall=1 for 3 cycles while ID changes.
  - Required: ex_* outputs constant for all 3 cycles; id_stall=1 throughout.
- x0 destination:
  - Stimulus: EX=lw x0; ID=add x1,x0,x0.
  - Required: no stall.
- Reset mid-stall:
  - Stimulus: rst=1 during a hazard cycle.
  - Required: next edge gives ex_valid=0, ex_inst=0x00000013, all control bits 0, and counters 0.
